// File: rtl/systolic_result_drain.sv
// Snapshot-and-drain reader for the NxN systolic MAC array: captures the
// packed result matrix on i_start and streams it row-major with an int8 copy.

module systolic_result_drain_rq #(
  parameter int W = 32
) (
  input  logic [W-1:0] x_i,
  input  logic [4:0]   sh_i,
  output logic [7:0]   q_o
);
  localparam logic signed [W:0] QMAX = (W+1)'(127);
  localparam logic signed [W:0] QMIN = (W+1)'(-128);

  logic signed [W:0] rnd, t, q;

  // One extra bit keeps x + 2^(sh-1) from overflowing for any W-bit x.
  always_comb begin
    rnd = '0;
    if (sh_i != 5'd0) rnd = (W+1)'(1) << (sh_i - 5'd1);
    t = $signed({x_i[W-1], x_i}) + rnd;
    q = t >>> sh_i;
    if (q > QMAX)      q_o = 8'h7f;
    else if (q < QMIN) q_o = 8'h80;
    else               q_o = q[7:0];
  end
endmodule

module systolic_result_drain #(
  parameter  int N  = 8,
  parameter  int W  = 32,
  localparam int RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_arst_n,
  input  logic                         i_start,
  input  logic [4:0]                   i_shift,
  input  logic [N-1:0][N-1:0][W-1:0]   i_c,
  output logic                         o_busy,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [W-1:0]                 o_data,
  output logic [7:0]                   o_q8,
  output logic [RW-1:0]                o_row,
  output logic [RW-1:0]                o_col,
  output logic                         o_last,
  output logic                         o_done
);
  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

  localparam logic [RW-1:0] IDX_LAST = RW'(N-1);

  state_t                      state_q, state_d;
  logic [RW-1:0]               row_q, row_d, col_q, col_d;
  logic [4:0]                  shift_q;
  logic [N-1:0][N-1:0][W-1:0]  buf_q;
  logic                        cap;
  logic [W-1:0]                elem;
  logic [7:0]                  q8_w;

  assign cap = (state_q == S_IDLE) && i_start;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      if (cap) shift_q <= i_shift;
    end
  end

  // Buffer contents are don't-care after reset, so no reset on the wide array.
  always_ff @(posedge i_clk) begin
    if (cap) buf_q <= i_c;
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_DRAIN;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_DRAIN: begin
        if (i_ready) begin
          if (col_q == IDX_LAST) begin
            col_d = '0;
            if (row_q == IDX_LAST) begin
              row_d   = '0;
              state_d = S_DONE;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + RW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign elem = buf_q[row_q][col_q];

  systolic_result_drain_rq #(.W(W)) u_rq (
    .x_i  (elem),
    .sh_i (shift_q),
    .q_o  (q8_w)
  );

  // Data paths are gated so outputs read zero whenever no beat is offered.
  assign o_valid = (state_q == S_DRAIN);
  assign o_busy  = (state_q != S_IDLE);
  assign o_done  = (state_q == S_DONE);
  assign o_row   = row_q;
  assign o_col   = col_q;
  assign o_last  = o_valid && (row_q == IDX_LAST) && (col_q == IDX_LAST);
  assign o_data  = o_valid ? elem : '0;
  assign o_q8    = o_valid ? q8_w : '0;
endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: drain order, backpressure,
// requantization, snapshot isolation, ignored starts and async reset.
module tb_systolic_result_drain;
  localparam int N = 8;
  localparam int W = 32;

  logic clk = 1'b0, arst_n = 1'b0, start = 1'b0, ready = 1'b0;
  logic [4:0] shift = '0;
  logic [N-1:0][N-1:0][W-1:0] mat = '0;
  logic busy, valid, last, done;
  logic [W-1:0] data;
  logic [7:0] q8;
  logic [2:0] row, col;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  systolic_result_drain #(.N(N), .W(W)) dut (
    .i_clk(clk), .i_arst_n(arst_n), .i_start(start), .i_shift(shift), .i_c(mat),
    .o_busy(busy), .o_valid(valid), .i_ready(ready), .o_data(data), .o_q8(q8),
    .o_row(row), .o_col(col), .o_last(last), .o_done(done)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick; @(negedge clk); endtask

  task automatic fill(input int base, input int mul);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mat[r][c] = W'(base + mul * (r * N + c));
  endtask

  task automatic kick(input logic [4:0] s);
    shift = s; start = 1'b1; tick; start = 1'b0;
  endtask

  task automatic finish_drain(output bit ok);
    ok = 1'b0; ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (done) begin ok = 1'b1; break; end
      tick;
    end
    tick; ready = 1'b0;
  endtask

  task automatic test_reset;
    bit ok;
    tick; tick;
    checks++;
    if ({busy, valid, last, done, data, q8, row, col} !== '0)
      begin errors++; $display("FAIL reset_init: got b=%b v=%b l=%b d=%b data=%0d q=%0d required all 0", busy, valid, last, done, data, q8); end
    arst_n = 1'b1;
    tick;
    fill(0, 1); ready = 1'b1; kick(5'd0);
    for (int i = 0; i < 29; i++) tick;
    checks++;
    if ({valid, data, row, col} !== {1'b1, 32'd29, 3'd3, 3'd5})
      begin errors++; $display("FAIL reset_pre: got v=%b d=%0d r=%0d c=%0d required 1 29 3 5", valid, data, row, col); end
    #1 arst_n = 1'b0;
    #1;
    checks++;
    if ({busy, valid, last, done, data, q8, row, col} !== '0)
      begin errors++; $display("FAIL reset_async: got b=%b v=%b d=%0d r=%0d c=%0d required all 0", busy, valid, data, row, col); end
    #1 arst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if ({busy, valid, done} !== 3'b000)
        begin errors++; $display("FAIL reset_after cyc %0d: got b=%b v=%b d=%b required 000", i, busy, valid, done); end
    end
    fill(100, 1); kick(5'd0);
    checks++;
    if ({valid, data, row, col} !== {1'b1, 32'd100, 3'd0, 3'd0})
      begin errors++; $display("FAIL reset_restart: got v=%b d=%0d r=%0d c=%0d required 1 100 0 0", valid, data, row, col); end
    finish_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_drain: got no done required done"); end
  endtask

  task automatic test_full_drain;
    fill(0, 1); ready = 1'b1; kick(5'd0);
    for (int b = 0; b < N * N; b++) begin
      checks++;
      if ({valid, done, data, row, col, last, q8} !== {1'b1, 1'b0, 32'(b), 3'(b / N), 3'(b % N), (b == 63), 8'(b)})
        begin errors++; $display("FAIL full_drain beat %0d: got v=%b dn=%b d=%0d r=%0d c=%0d l=%b q=%0d", b, valid, done, data, row, col, last, q8); end
      tick;
    end
    checks++;
    if ({done, valid, busy} !== 3'b101)
      begin errors++; $display("FAIL full_done: got done=%b v=%b busy=%b required 1 0 1", done, valid, busy); end
    tick;
    checks++;
    if ({done, busy} !== 2'b00)
      begin errors++; $display("FAIL full_idle: got done=%b busy=%b required 0 0", done, busy); end
    ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int idx = 0, n = 0;
    bit stalled = 1'b0, r;
    logic [48:0] prev = '0, cur;
    fill(0, 1); ready = 1'b0; kick(5'd0);
    while (!done && n < 2000) begin
      checks++;
      if (!valid) begin errors++; $display("FAIL bp_valid cyc %0d: got v=0 required 1", n); break; end
      cur = {data, row, col, last, q8};
      checks++;
      if ({data, row, col, last} !== {32'(idx), 3'(idx / N), 3'(idx % N), (idx == 63)})
        begin errors++; $display("FAIL bp_elem idx %0d: got d=%0d r=%0d c=%0d l=%b", idx, data, row, col, last); end
      if (stalled) begin
        checks++;
        if (cur !== prev) begin errors++; $display("FAIL bp_stable idx %0d: got %h required %h", idx, cur, prev); end
      end
      prev = cur;
      r = ($urandom_range(0, 9) < 3);
      ready = r; stalled = !r;
      if (r) idx++;
      tick; n++;
    end
    checks++;
    if (!done || idx != N * N)
      begin errors++; $display("FAIL bp_done: got done=%b beats=%0d required 1 64", done, idx); end
    ready = 1'b0; tick;
  endtask

  task automatic test_requant;
    int xs[11] = '{5, -3, 1000, 32'h7FFFFFFF, int'(32'h80000000), -1000, 6, -6, -5, 128, -129};
    int ss[11] = '{1, 1, 2, 0, 31, 0, 2, 2, 1, 0, 0};
    int es[11] = '{3, -1, 127, 127, -1, -128, 2, -1, -2, 127, -128};
    bit ok;
    for (int i = 0; i < 11; i++) begin
      mat = '0; mat[0][0] = 32'(xs[i]); ready = 1'b0;
      kick(5'(ss[i]));
      checks++;
      if ({data, q8} !== {32'(xs[i]), 8'(es[i])})
        begin errors++; $display("FAIL requant %0d: x=%0d sh=%0d got d=%0d q=%0d required q=%0d", i, xs[i], ss[i], $signed(data), $signed(q8), es[i]); end
      finish_drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL requant_drain %0d: got no done required done", i); end
    end
  endtask

  task automatic test_snapshot;
    logic [N-1:0][N-1:0][W-1:0] snap;
    fill(1000, 1); snap = mat; ready = 1'b1; kick(5'd0);
    for (int b = 0; b < N * N; b++) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) mat[r][c] = $urandom;
      checks++;
      if (data !== snap[b / N][b % N])
        begin errors++; $display("FAIL snapshot beat %0d: got %0d required %0d", b, data, snap[b / N][b % N]); end
      tick;
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL snapshot_done: got %b required 1", done); end
    tick; ready = 1'b0;
  endtask

  task automatic test_ignored_start;
    bit ok;
    fill(0, 3); ready = 1'b1; kick(5'd0);
    for (int b = 0; b < N * N; b++) begin
      checks++;
      if ({valid, done, data, row, col} !== {1'b1, 1'b0, 32'(3 * b), 3'(b / N), 3'(b % N)})
        begin errors++; $display("FAIL ign_beat %0d: got v=%b dn=%b d=%0d r=%0d c=%0d", b, valid, done, data, row, col); end
      start = (b == 10 || b == 63);
      if (b == 10) fill(0, 5);
      tick;
    end
    checks++;
    if ({done, valid} !== 2'b10)
      begin errors++; $display("FAIL ign_done: got done=%b v=%b required 1 0", done, valid); end
    start = 1'b1; fill(7, 3);
    tick;
    checks++;
    if ({valid, busy, done} !== 3'b000)
      begin errors++; $display("FAIL ign_idle: got v=%b busy=%b done=%b required 000", valid, busy, done); end
    tick; start = 1'b0;
    checks++;
    if ({valid, data, row, col} !== {1'b1, 32'd7, 3'd0, 3'd0})
      begin errors++; $display("FAIL ign_accept: got v=%b d=%0d r=%0d c=%0d required 1 7 0 0", valid, data, row, col); end
    finish_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ign_drain: got no done required done"); end
  endtask

  initial begin
    test_reset;
    test_full_drain;
    test_backpressure;
    test_requant;
    test_snapshot;
    test_ignored_start;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Output-side reader for the N×N systolic MAC array. When the controller signals that accumulation has finished, it snapshots the array's packed 32-bit result matrix. It then streams the elements row-major over a valid/ready interface, one element per beat. Each beat carries the raw 32-bit accumulator plus an int8 requantized copy for the next layer's activation buffer. It sits between the array's result port and the output buffer/DMA writer.

## Interface
- N, 8, array dimension (rows = cols = N)
- W, 32, accumulator width per element
- i_clk  input  1  clock, all state on rising edge
- i_arst_n  input  1  asynchronous active-low reset
- i_start  input  1  capture request; one-cycle pulse from controller when results are final
- i_shift  input  5  requantization right-shift amount, sampled with i_start
- i_c  input  N*N*W, packed [N-1:0][N-1:0][W-1:0] signed  result matrix, element [r][c]
- o_busy  output  1  high from capture until drain completes (states DRAIN and DONE)
- o_valid  output  1  stream element valid
- i_ready  input  1  downstream accepts element
- o_data  output  W  signed raw accumulator of current element
- o_q8  output  8  signed requantized current element
- o_row  output  $clog2(N)  row index of current element
- o_col  output  $clog2(N)  column index of current element
- o_last  output  1  current element is [N-1][N-1]
- o_done  output  1  one-cycle pulse after final element is accepted

## Operation
- Internal snapshot buffer holds N*N×W bits plus the latched shift. i_c is not referenced after capture, so the array may start its next job immediately.
- FSM states:
  - IDLE:
    - i_start=1 → capture i_c into the buffer and i_shift into shift_q; clear row/col counters; go to DRAIN.
  - DRAIN:
    - o_valid=1.
    - On o_valid&&i_ready: advance col. At col=N-1, wrap col to 0 and increment row.
    - Transfer of [N-1][N-1] → DONE.
  - DONE:
    - o_done=1, o_valid=0 for exactly one cycle, then go to IDLE.
- i_start is honoured only in IDLE. It is ignored in DRAIN and DONE, including when it coincides with the final transfer or with the DONE cycle. The buffer is never overwritten mid-drain.
- Handshake rules:
  - o_valid, o_data, o_q8, o_row, o_col, o_last stay stable while o_valid=1 and i_ready=0.
  - o_valid never drops before its transfer completes.
  - i_ready may be asserted in any state; it is ignored unless o_valid=1.
- Requantization:
  - t = sext33(x) + (shift_q>0 ? 1<<(shift_q-1) : 0).
  - q = t >>> shift_q (arithmetic shift; rounding is round-half-up).
  - Saturate q to [-128, 127].
  - o_q8 is combinational from the current buffer element and shift_q.
- o_last = (o_row==N-1)&&(o_col==N-1)&&o_valid.

## Timing
- Reset values: state IDLE; o_busy, o_valid, o_last, o_done = 0; o_data, o_q8, o_row, o_col = 0; buffer contents don't-care.
- Reset asserted mid-drain aborts immediately (asynchronously). No o_done is produced.
- Capture: i_start is sampled at edge k. o_valid=1 with element [0][0] is presented from cycle k+1.
- Throughput: with i_ready held high, one element per cycle. N*N beats occupy cycles k+1..k+N*N.
- o_done is high in cycle k+N*N+1, and o_busy falls at the end of that cycle.
- A new i_start is accepted at earliest in cycle k+N*N+2.
- Total latency, start to done, is N*N+1 cycles plus the number of stall cycles.

## Test plan
- **Reset:** assert i_arst_n=0 mid-drain at element [3][5] → all outputs 0 immediately. After release, o_valid=0 and no o_done. A fresh i_start restarts at [0][0].
- **Full drain, N=8, i_ready=1:**
  - Stimulus: i_c[r][c]=r*8+c, i_shift=0.
  - o_data sequence is 0..63 on consecutive cycles.
  - o_last is set only on beat 63.
  - o_done is set 65 cycles after i_start.
- **Backpressure:** random i_ready at 30% high → identical o_data sequence and indices. Outputs hold stable during every stall; no element is dropped or duplicated.
- **Requantization:**
  - (x=5, shift=1) → 3
  - (x=-3, shift=1) → -1
  - (x=1000, shift=2) → 127
  - (x=0x7FFFFFFF, shift=0) → 127
  - (x=0x80000000, shift=31) → -1
  - (x=-1000, shift=0) → -128
- **Snapshot isolation:** change i_c every cycle after capture → streamed values equal those present at the capture edge.
- **Ignored start:** pulse i_start during DRAIN, on the final transfer cycle, and on the DONE cycle → no restart and exactly one o_done. An i_start on the cycle after DONE is accepted.
